// File: rtl/pr_bus_arbiter_pkg.sv
// Shared types and constants for the two-master Pr* bus arbiter.
//   AW/DW/CW  : word-address, data and starvation-counter widths
//   state_e   : arbiter FSM encoding
//   master_e  : master identifiers
//   bus_req_t : one latched bus request (address, write data, write enable)
package pr_bus_arbiter_pkg;

  localparam int unsigned AW = 30;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_e;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          we;
  } bus_req_t;

endpackage

// File: rtl/pr_prio_sel.sv
// Combinational winner selector: fixed M0 priority with a starvation limit
// that forces M1 through after STARVE_LIMIT consecutive contested M0 wins.
//   elig_i        : eligible requests {M1, M0}
//   cnt_i         : current starvation count
//   grant_valid_o : some master wins this edge
//   grant_id_o    : winning master
//   cnt_next_o    : starvation count after this edge
module pr_prio_sel
  import pr_bus_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic [1:0]    elig_i,
  input  logic [CW-1:0] cnt_i,
  output logic          grant_valid_o,
  output master_e       grant_id_o,
  output logic [CW-1:0] cnt_next_o
);

  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  always_comb begin
    grant_valid_o = 1'b0;
    grant_id_o    = M0;
    cnt_next_o    = cnt_i;
    case (elig_i)
      2'b01: begin
        grant_valid_o = 1'b1;
        grant_id_o    = M0;
        cnt_next_o    = '0;
      end
      2'b10: begin
        grant_valid_o = 1'b1;
        grant_id_o    = M1;
        cnt_next_o    = '0;
      end
      2'b11: begin
        grant_valid_o = 1'b1;
        // Below the limit the increment cannot exceed LIMIT, so no wrap.
        if (cnt_i < LIMIT) begin
          grant_id_o = M0;
          cnt_next_o = cnt_i + CW'(1);
        end else begin
          grant_id_o = M1;
          cnt_next_o = '0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pr_bus_arbiter.sv
// Two-master arbiter in front of the Pr* system bridge. Latches one request
// per transaction, drives the bridge for exactly one ACCESS cycle, captures
// PrRD for reads and returns a one-cycle done pulse to the winner.
//   clk, reset_n        : clock, async active-low reset
//   mN_req/addr/wdata/we: master N request, held until mN_done
//   mN_done, mN_rdata   : completion pulse and read data for master N
//   PrAddr/PrWD/PrWE    : bridge address, write data, write enable
//   PrRD                : bridge read data (combinational from PrAddr)
//   busy                : high in ACCESS and RESP
module pr_bus_arbiter
  import pr_bus_arbiter_pkg::*;
#(
  parameter int unsigned   STARVE_LIMIT = 4,
  parameter logic [AW-1:0] IDLE_ADDR    = '0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_we,
  output logic          m0_done,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_we,
  output logic          m1_done,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] PrAddr,
  output logic [DW-1:0] PrWD,
  output logic          PrWE,
  input  logic [DW-1:0] PrRD,
  output logic          busy
);

  state_e        state_q, state_d;
  master_e       owner_q, owner_d;
  logic [CW-1:0] starve_q, starve_d;
  logic [AW-1:0] pr_addr_q, pr_addr_d;
  logic [DW-1:0] pr_wd_q, pr_wd_d;
  logic          pr_we_q, pr_we_d;
  logic          m0_done_q, m0_done_d;
  logic          m1_done_q, m1_done_d;
  logic [DW-1:0] m0_rdata_q, m0_rdata_d;
  logic [DW-1:0] m1_rdata_q, m1_rdata_d;
  logic          busy_q, busy_d;

  logic [1:0]    elig_c;
  logic          grant_valid_c;
  master_e       grant_id_c;
  logic [CW-1:0] cnt_next_c;
  bus_req_t      win_c;

  // The master being completed in RESP is masked so a stale req is not re-granted.
  assign elig_c[0] = m0_req & ~((state_q == ST_RESP) & (owner_q == M0));
  assign elig_c[1] = m1_req & ~((state_q == ST_RESP) & (owner_q == M1));

  pr_prio_sel #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio_sel (
    .elig_i       (elig_c),
    .cnt_i        (starve_q),
    .grant_valid_o(grant_valid_c),
    .grant_id_o   (grant_id_c),
    .cnt_next_o   (cnt_next_c)
  );

  // Winner's request payload, latched into the bridge registers on grant.
  always_comb begin
    win_c = '{addr: m0_addr, wdata: m0_wdata, we: m0_we};
    if (grant_id_c == M1) begin
      win_c = '{addr: m1_addr, wdata: m1_wdata, we: m1_we};
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    starve_d   = starve_q;
    pr_addr_d  = IDLE_ADDR;
    pr_wd_d    = '0;
    pr_we_d    = 1'b0;
    m0_done_d  = 1'b0;
    m1_done_d  = 1'b0;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    busy_d     = 1'b0;

    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (grant_valid_c) begin
          state_d   = ST_ACCESS;
          owner_d   = grant_id_c;
          starve_d  = cnt_next_c;
          pr_addr_d = win_c.addr;
          pr_wd_d   = win_c.wdata;
          pr_we_d   = win_c.we;
          busy_d    = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        // Closing edge of the access: capture read data and signal done.
        state_d = ST_RESP;
        busy_d  = 1'b1;
        if (owner_q == M1) begin
          m1_done_d = 1'b1;
          if (!pr_we_q) m1_rdata_d = PrRD;
        end else begin
          m0_done_d = 1'b1;
          if (!pr_we_q) m0_rdata_d = PrRD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= M0;
      starve_q   <= '0;
      pr_addr_q  <= IDLE_ADDR;
      pr_wd_q    <= '0;
      pr_we_q    <= 1'b0;
      m0_done_q  <= 1'b0;
      m1_done_q  <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      starve_q   <= starve_d;
      pr_addr_q  <= pr_addr_d;
      pr_wd_q    <= pr_wd_d;
      pr_we_q    <= pr_we_d;
      m0_done_q  <= m0_done_d;
      m1_done_q  <= m1_done_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
      busy_q     <= busy_d;
    end
  end

  assign PrAddr   = pr_addr_q;
  assign PrWD     = pr_wd_q;
  assign PrWE     = pr_we_q;
  assign m0_done  = m0_done_q;
  assign m1_done  = m1_done_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_pr_bus_arbiter.sv
// Self-checking bench for pr_bus_arbiter: transaction-level reference model
// feeding a scoreboard queue, with a monitor that checks bus outputs every
// cycle and pops expected completions on each done pulse.
module tb_pr_bus_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        m0_req = 1'b0, m1_req = 1'b0;
  logic [29:0] m0_addr = '0, m1_addr = '0;
  logic [31:0] m0_wdata = '0, m1_wdata = '0;
  logic        m0_we = 1'b0, m1_we = 1'b0;
  logic        m0_done, m1_done;
  logic [31:0] m0_rdata, m1_rdata;
  logic [29:0] PrAddr;
  logic [31:0] PrWD;
  logic        PrWE;
  logic [31:0] PrRD;
  logic        busy;

  always #5 clk = ~clk;

  // Bridge read data: a simple function of the address.
  function automatic logic [31:0] rd_fn(input logic [29:0] a);
    return 32'hDEAD0000 + 32'(a) - 32'h1FC0;
  endfunction
  assign PrRD = rd_fn(PrAddr);

  pr_bus_arbiter #(
    .STARVE_LIMIT(LIMIT),
    .IDLE_ADDR   (30'h0)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .m0_req  (m0_req),
    .m0_addr (m0_addr),
    .m0_wdata(m0_wdata),
    .m0_we   (m0_we),
    .m0_done (m0_done),
    .m0_rdata(m0_rdata),
    .m1_req  (m1_req),
    .m1_addr (m1_addr),
    .m1_wdata(m1_wdata),
    .m1_we   (m1_we),
    .m1_done (m1_done),
    .m1_rdata(m1_rdata),
    .PrAddr  (PrAddr),
    .PrWD    (PrWD),
    .PrWE    (PrWE),
    .PrRD    (PrRD),
    .busy    (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  typedef struct {
    int          id;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state: transaction in flight, master just completed,
  // starvation count, and expected bus outputs for the current cycle.
  int          m_inflight = -1;
  int          m_resp = -1;
  int          m_starve = 0;
  int          cyc = 0;
  logic [31:0] m_rdata [2] = '{32'h0, 32'h0};
  logic [29:0] e_addr = '0;
  logic [31:0] e_wd = '0;
  logic        e_we = 1'b0;
  logic        e_busy = 1'b0;
  logic        e_acc = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_inflight = -1;
      m_resp     = -1;
      m_starve   = 0;
      m_rdata    = '{32'h0, 32'h0};
      exp_q.delete();
      e_addr = '0; e_wd = '0; e_we = 1'b0; e_busy = 1'b0; e_acc = 1'b0;
    end else begin
      cyc++;
      if (m_inflight >= 0) begin
        m_resp     = m_inflight;
        m_inflight = -1;
        e_addr = '0; e_we = 1'b0; e_busy = 1'b1; e_acc = 1'b0;
      end else begin
        bit e0, e1;
        int win;
        e0  = m0_req && (m_resp != 0);
        e1  = m1_req && (m_resp != 1);
        win = -1;
        if (e0 && e1) begin
          if (m_starve < LIMIT) begin win = 0; m_starve++; end
          else begin win = 1; m_starve = 0; end
        end else if (e0) begin
          win = 0; m_starve = 0;
        end else if (e1) begin
          win = 1; m_starve = 0;
        end
        m_resp = -1;
        if (win >= 0) begin
          logic [31:0] rv;
          e_addr = (win == 1) ? m1_addr : m0_addr;
          e_wd   = (win == 1) ? m1_wdata : m0_wdata;
          e_we   = (win == 1) ? m1_we : m0_we;
          e_busy = 1'b1;
          e_acc  = 1'b1;
          rv = e_we ? m_rdata[win] : rd_fn(e_addr);
          m_rdata[win] = rv;
          m_inflight   = win;
          exp_q.push_back('{win, rv, cyc + 1});
        end else begin
          e_addr = '0; e_we = 1'b0; e_busy = 1'b0; e_acc = 1'b0;
        end
      end
    end
  end

  // Monitor: bus outputs every cycle, completions against the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      check("busy", 32'(busy), 32'(e_busy));
      check("PrWE", 32'(PrWE), 32'(e_we));
      check("PrAddr", 32'(PrAddr), 32'(e_addr));
      if (e_acc) check("PrWD", PrWD, e_wd);
      if (m0_done && m1_done) begin
        n_cmp++; n_bad++;
        $display("FAIL dual_done: got both done high expected at most one at %0t", $time);
      end else if (m0_done || m1_done) begin
        int id;
        id = m1_done ? 1 : 0;
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_done: got done from M%0d expected none at %0t", id, $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("done_id", 32'(id), 32'(e.id));
          check("rdata", (id == 1) ? m1_rdata : m0_rdata, e.rdata);
          check("done_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  int mode = 0;

  task automatic new_m0();
    m0_req   = 1'b1;
    m0_addr  = 30'h1FC0 + 30'($urandom_range(15, 0));
    m0_wdata = $urandom;
    m0_we    = 1'($urandom_range(1, 0));
  endtask

  task automatic new_m1();
    m1_req   = 1'b1;
    m1_addr  = 30'h1FC0 + 30'($urandom_range(15, 0));
    m1_wdata = $urandom;
    m1_we    = 1'($urandom_range(1, 0));
  endtask

  // One clock step; masters drop (or in random mode possibly renew) on done.
  task automatic step();
    int r;
    @(posedge clk);
    #1;
    if (reset_n) begin
      if (m0_done) begin
        if (mode == 1 && $urandom_range(1, 0) == 1) new_m0(); else m0_req = 1'b0;
      end else if (mode == 1) begin
        r = int'($urandom_range(99, 0));
        if (!m0_req) begin
          if (r < 40) new_m0();
        end else if (r < 4) begin
          m0_req = 1'b0;
        end else if (r < 20) begin
          m0_addr = 30'h1FC0 + 30'($urandom_range(15, 0)); m0_wdata = $urandom;
        end
      end
      if (m1_done) begin
        if (mode == 1 && $urandom_range(1, 0) == 1) new_m1(); else m1_req = 1'b0;
      end else if (mode == 1) begin
        r = int'($urandom_range(99, 0));
        if (!m1_req) begin
          if (r < 40) new_m1();
        end else if (r < 4) begin
          m1_req = 1'b0;
        end else if (r < 20) begin
          m1_addr = 30'h1FC0 + 30'($urandom_range(15, 0)); m1_wdata = $urandom;
        end
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    m0_req  = 1'b0;
    m1_req  = 1'b0;
    #1;
    check("rst_PrWE", 32'(PrWE), 32'h0);
    check("rst_PrAddr", 32'(PrAddr), 32'h0);
    check("rst_PrWD", PrWD, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_m0_done", 32'(m0_done), 32'h0);
    check("rst_m1_done", 32'(m1_done), 32'h0);
    check("rst_m0_rdata", m0_rdata, 32'h0);
    check("rst_m1_rdata", m1_rdata, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 reset_n = 1'b1;
  endtask

  initial begin
    do_reset();

    // Single M0 read.
    step();
    m0_req = 1'b1; m0_addr = 30'h1FC1; m0_wdata = 32'h0; m0_we = 1'b0;
    repeat (4) step();

    // M1 read, then M1 write (rdata must hold the read value).
    step();
    m1_req = 1'b1; m1_addr = 30'h1FC2; m1_wdata = 32'h0; m1_we = 1'b0;
    repeat (4) step();
    m1_req = 1'b1; m1_addr = 30'h1FC4; m1_wdata = 32'h5; m1_we = 1'b1;
    repeat (4) step();

    // Starvation: contested IDLE grants until M1 is forced through.
    for (int it = 0; it < LIMIT + 1; it++) begin
      step();
      m0_req = 1'b1; m0_addr = 30'h1FC0 + 30'(it); m0_we = 1'b0;
      m1_req = 1'b1; m1_addr = 30'h1FC8 + 30'(it); m1_we = 1'b0;
      step();
      m1_req = 1'b0;
      repeat (5) step();
    end

    // Simultaneous first request: M0 then M1 back to back.
    step();
    m0_req = 1'b1; m0_addr = 30'h1FC3; m0_we = 1'b0;
    m1_req = 1'b1; m1_addr = 30'h1FC6; m1_wdata = 32'hA5A5_0001; m1_we = 1'b1;
    repeat (8) step();

    // Reset during the ACCESS cycle of a write.
    step();
    m1_req = 1'b1; m1_addr = 30'h1FC7; m1_wdata = 32'h1234_5678; m1_we = 1'b1;
    step();
    check("access_PrWE", 32'(PrWE), 32'h1);
    do_reset();
    repeat (4) step();
    m0_req = 1'b1; m0_addr = 30'h1FC5; m0_we = 1'b0;
    repeat (5) step();

    // Randomized traffic.
    mode = 1;
    repeat (3000) step();
    mode = 0;
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0 && !m0_req && !m1_req && !busy) break;
      step();
    end
    n_cmp++;
    if (exp_q.size() != 0 || m0_req || m1_req) begin
      n_bad++;
      $display("FAIL drain: got %0d pending completions expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pr_bus_arbiter.md
Name: pr_bus_arbiter

Overview:
- Two-master arbiter in front of the system bridge (Pr* bus), so the CPU data port (M0) and a secondary bus master such as a DMA/debug port (M1) can share the timer/device address space.
- Latches one request per transaction and drives the bridge for exactly one access cycle. Captures the bridge read data and returns a one-cycle done pulse to the winner.
- Priority is fixed to M0, with a starvation limit that forces an M1 grant.

Parameters:
- STARVE_LIMIT, 4, consecutive M0 grants while M1 is requesting before M1 is forced through (legal range 1..15).
- IDLE_ADDR, 30'h0, value driven on PrAddr when no access is in progress.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- m0_req  in  1  M0 request; held with addr/wdata/we until m0_done.
- m0_addr  in  30  M0 word address [31:2].
- m0_wdata  in  32  M0 write data.
- m0_we  in  1  M0 write enable (1 = write, 0 = read).
- m0_done  out  1  one-cycle completion pulse to M0.
- m0_rdata  out  32  M0 read data, valid while m0_done = 1.
- m1_req, m1_addr, m1_wdata, m1_we, m1_done, m1_rdata: same widths and meaning as the M0 ports, for M1.
- PrAddr  out  30  bridge word address [31:2].
- PrWD  out  32  bridge write data.
- PrWE  out  1  bridge write enable.
- PrRD  in  32  bridge read data (combinational from PrAddr).
- busy  out  1  high in the ACCESS and RESP states.

Behaviour:
- Reset (async, reset_n = 0):
  - state = IDLE; starve_cnt = 0.
  - Request latches cleared; owner = M0.
  - PrAddr = IDLE_ADDR, PrWD = 0, PrWE = 0.
  - m0_done = m1_done = 0; m0_rdata = m1_rdata = 0; busy = 0.
  - Asserting reset during ACCESS kills the access immediately; PrWE drops asynchronously and no done pulse is issued afterwards.
- States:
  - IDLE: bus idle; arbitrate.
  - ACCESS: latched addr/wdata/we of the owner drive PrAddr/PrWD/PrWE for exactly one cycle. PrRD is registered into the owner's rdata at the closing edge.
  - RESP: owner's done = 1 for this cycle only; rdata valid; PrWE = 0, PrAddr = IDLE_ADDR. Arbitrate again here.
- Transitions:
  - IDLE to ACCESS when any eligible req = 1 at a clock edge; otherwise stay in IDLE.
  - ACCESS to RESP always.
  - RESP to ACCESS if an eligible req exists, else RESP to IDLE.
- Eligibility: in RESP, the master currently being completed is not eligible. This lets it drop req in its done cycle, and prevents a stale req from being re-granted.
- Arbitration (registered; winner's addr/wdata/we latched at the granting edge):
  - Only M0 requesting: M0 wins.
  - Only M1 requesting: M1 wins.
  - Both requesting and starve_cnt < STARVE_LIMIT: M0 wins, starve_cnt += 1.
  - Both requesting and starve_cnt == STARVE_LIMIT: M1 wins.
  - Any M1 grant clears starve_cnt to 0.
  - An M0 grant with M1 not requesting clears starve_cnt to 0.
  - starve_cnt saturates at STARVE_LIMIT and never wraps.
- Latency: req sampled at edge k gives ACCESS in cycle k..k+1 and done in the cycle after edge k+1, i.e. 2 cycles.
- Throughput: back-to-back alternating grants give one access every 2 cycles.
- Reads: rdata is never written on writes. For a write, the done master's rdata holds its previous value.
- Request/address rules: req deasserted before done is a protocol violation; the latched copy still completes. Address and data changes after the grant edge are ignored.
- Writes: PrWE = 1 is asserted for exactly one cycle per write transaction and never in IDLE or RESP.

Decomposition:
- Shared package: state encoding constants (IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2) and master IDs (M0 = 1'b0, M1 = 1'b1).
- One natural sub-module, pr_prio_sel: a combinational winner selector.
  - Inputs: two eligible reqs, starve_cnt, STARVE_LIMIT.
  - Outputs: grant_valid, grant_id, cnt_next.
- The FSM, request latches and rdata registers stay in pr_bus_arbiter.

Test Plan:
1. Reset then single M0 read: m0_req = 1, m0_addr = 30'h1FC1 (byte 0x7F04), m0_we = 0, bench PrRD = 32'hDEAD0001 → PrAddr = 30'h1FC1 in ACCESS; m0_done pulse 2 cycles after the req edge with m0_rdata = 32'hDEAD0001; PrWE stays 0.
2. M1 write: m1_addr = 30'h1FC4 (0x7F10), m1_wdata = 32'h5, m1_we = 1 → PrWE = 1 for exactly one cycle with PrWD = 32'h5; m1_done pulses; m1_rdata is unchanged.
3. Starvation, STARVE_LIMIT = 4: both masters hold req continuously, each dropping and re-raising after its done → grant order M0, M0, M0, M0, M1, M0, …; done pulses every 2 cycles.
4. Simultaneous first request with starve_cnt = 0 → M0 is granted first and M1 next, from RESP directly to ACCESS with no IDLE cycle.
5. reset_n low during ACCESS of a write → PrWE falls immediately; after release, state is IDLE and no done pulse is issued; a subsequent M0 read completes normally.
6. Master drops req in its done cycle with the other master idle → FSM returns to IDLE; PrAddr = IDLE_ADDR, PrWE = 0, busy = 0.
